ysyx_22051086_mem_arb: RTL and testbench
========================================

# ysyx_22051086_mem_arb

Two-requester memory arbiter for the NPC pipeline: instruction fetch (IF) and load/store (LS) share one downstream memory port. One transaction is outstanding at a time. LS has fixed priority, bounded by an IF anti-starvation counter. Responses are routed back to the owner, and a branch-flush input discards stale fetch responses.

## Interface
Parameters:
- `ADDR_W`, 64, address width (matches pc width)
- `DATA_W`, 64, data width
- `STARVE_MAX`, 4, number of consecutive LS wins while IF waits before IF is forced through

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-low
- `if_req_valid`  in  1  fetch request
- `if_req_ready`  out  1  fetch request accepted this cycle
- `if_req_addr`  in  ADDR_W  fetch address
- `if_flush`  in  1  branch taken; kill the in-flight or presented fetch
- `if_resp_valid`  out  1  fetch data valid (single-cycle pulse)
- `if_resp_data`  out  DATA_W  fetch data
- `ls_req_valid`  in  1  load/store request
- `ls_req_ready`  out  1  load/store request accepted
- `ls_req_addr`  in  ADDR_W  address
- `ls_req_wen`  in  1  1 = store
- `ls_req_wdata`  in  DATA_W  store data
- `ls_req_wmask`  in  DATA_W/8  byte strobes
- `ls_resp_valid`  out  1  load data / store ack pulse
- `ls_resp_data`  out  DATA_W  load data (don't-care for stores)
- `mem_req_valid`  out  1  downstream request
- `mem_req_ready`  in  1  downstream accepts
- `mem_req_addr`, `mem_req_wen`, `mem_req_wdata`, `mem_req_wmask`  out  as LS  latched request fields
- `mem_resp_valid`  in  1  downstream response; always accepted
- `mem_resp_data`  in  DATA_W  response data
- `busy`  out  1  state != IDLE

## Operation
- FSM: IDLE, ISSUE, WAIT.
- **IDLE**
  - Grant LS if `ls_req_valid`.
  - Otherwise grant IF if `if_req_valid && !if_flush`.
  - Override: if `starve_cnt == STARVE_MAX` and IF is eligible, IF wins.
  - The granted `*_req_ready` is asserted combinationally in the same cycle.
  - Latch the request fields and `owner`, clear `drop`, and go to ISSUE.
  - IF fields: `wen = 0`, `wmask = 0`, `wdata = 0`.
- **ISSUE**
  - `mem_req_valid = 1` with the latched fields, held stable until `mem_req_ready`; then go to WAIT.
- **WAIT**
  - On `mem_resp_valid`, pulse `<owner>_resp_valid` with `mem_resp_data` combinationally (zero added latency), then go to IDLE.
  - If `drop` is set, or `if_flush` is high in the same cycle with `owner == IF`, suppress `if_resp_valid`.
- **Flush**
  - `if_flush` during ISSUE or WAIT with `owner == IF` sets `drop`.
  - The memory handshake still completes; valid is never retracted.
  - Flush never affects LS transactions.
- **Starvation counter** (`starve_cnt`, saturating at `STARVE_MAX`, width `$clog2(STARVE_MAX+1)`):
  - +1 on each IDLE grant to LS while IF was eligible.
  - Cleared on any IF grant.
- A `mem_resp_valid` outside WAIT is a protocol error and is ignored; no `resp_valid` is emitted.
- Reset (any state): state = IDLE; `owner`, `drop`, `starve_cnt` and latched fields = 0; all outputs 0. Any outstanding transaction is abandoned, and the downstream must be reset together with the arbiter.

## Timing
- Accept at cycle T → `mem_req_valid` from T+1.
- With zero-wait memory (ready and response next cycle): handshake at T+1, response at T+2, next accept at T+3.
- `*_req_ready` is only ever high in IDLE, and for at most one requester.
- `*_resp_valid` is at most one cycle per transaction and mutually exclusive.
- Downstream backpressure: ISSUE holds indefinitely while `mem_req_ready = 0`.

## Structure
- Shared header `ysyx_22051086_defs.vh`:
  - state localparams `ARB_IDLE=2'd0`, `ARB_ISSUE=2'd1`, `ARB_WAIT=2'd2`
  - owner encoding `OWN_IF=1'b0`, `OWN_LS=1'b1`
- Sub-module `ysyx_22051086_arb_pick`: combinational grant plus the registered starvation counter. It takes eligibility and an IDLE strobe, and outputs a one-hot grant. Everything else stays in the top module.

## Test plan
- **Single fetch:** IF `addr=0x80000000` with zero-wait memory, response `0x00100073` → `if_req_ready` at T, `mem_req_addr=0x80000000` at T+1, `if_resp_valid`/data at T+2, `busy` low at T+3.
- **Store:** LS store `addr=0x80001000`, `wdata=0xdeadbeef`, `wmask=0x0f`, with `mem_req_ready` held low for 3 cycles → fields stable throughout ISSUE, then `ls_resp_valid` pulses once.
- **Simultaneous requests:** IF and LS both valid → LS granted first, IF next. With LS continuously valid, IF is granted on the 5th arbitration (`STARVE_MAX=4`).
- **Flush in WAIT:** `if_flush` pulsed during WAIT of an IF fetch → no `if_resp_valid`, FSM returns to IDLE, and the next LS request proceeds normally.
- **Flush in IDLE:** `if_flush` with `if_req_valid` in IDLE and no LS request → no grant, `if_req_ready = 0`.
- **Async reset in ISSUE:** `rst` asserted low mid-cycle while in ISSUE → `mem_req_valid` and `busy` drop immediately, `starve_cnt = 0`, and a late `mem_resp_valid` produces no response pulse.

Source files
------------

// File: rtl/ysyx_22051086_mem_arb_pkg.sv
// rtl/ysyx_22051086_mem_arb_pkg.sv - shared state, owner and grant encodings for the memory arbiter
package ysyx_22051086_mem_arb_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_LS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = ARB_IDLE,
    ST_ISSUE = ARB_ISSUE,
    ST_WAIT  = ARB_WAIT
  } arb_state_e;

endpackage

// File: rtl/ysyx_22051086_mem_arb_if.sv
// rtl/ysyx_22051086_mem_arb_if.sv - fetch, load/store and downstream memory signals of the arbiter
interface ysyx_22051086_mem_arb_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  if_req_valid;
  logic                  if_req_ready;
  logic [ADDR_W-1:0]     if_req_addr;
  logic                  if_flush;
  logic                  if_resp_valid;
  logic [DATA_W-1:0]     if_resp_data;

  logic                  ls_req_valid;
  logic                  ls_req_ready;
  logic [ADDR_W-1:0]     ls_req_addr;
  logic                  ls_req_wen;
  logic [DATA_W-1:0]     ls_req_wdata;
  logic [DATA_W/8-1:0]   ls_req_wmask;
  logic                  ls_resp_valid;
  logic [DATA_W-1:0]     ls_resp_data;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_W-1:0]     mem_req_addr;
  logic                  mem_req_wen;
  logic [DATA_W-1:0]     mem_req_wdata;
  logic [DATA_W/8-1:0]   mem_req_wmask;
  logic                  mem_resp_valid;
  logic [DATA_W-1:0]     mem_resp_data;

  logic                  busy;

  // Arbiter side.
  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output if_req_ready, if_resp_valid, if_resp_data,
    output ls_req_ready, ls_resp_valid, ls_resp_data,
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output busy
  );

  // Requesters plus downstream memory.
  modport master (
    output if_req_valid, if_req_addr, if_flush,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_wdata, ls_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  if_req_ready, if_resp_valid, if_resp_data,
    input  ls_req_ready, ls_resp_valid, ls_resp_data,
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  busy
  );
endinterface

// File: rtl/ysyx_22051086_arb_pick.sv
// rtl/ysyx_22051086_arb_pick.sv - LS-priority grant with IF anti-starvation counter
module ysyx_22051086_arb_pick
  import ysyx_22051086_mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_idle,
  input  logic       i_if_elig,
  input  logic       i_ls_elig,
  output logic [1:0] o_grant
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_if;
  logic             w_grant_if;
  logic             w_grant_ls;

  // LS wins unless IF has already lost STARVE_MAX times in a row while waiting.
  assign w_force_if = (r_starve_cnt == CNT_MAX) && i_if_elig;
  assign w_grant_ls = i_idle && i_ls_elig && !w_force_if;
  assign w_grant_if = i_idle && i_if_elig && !w_grant_ls;

  always_comb begin
    o_grant         = 2'b00;
    o_grant[GNT_IF] = w_grant_if;
    o_grant[GNT_LS] = w_grant_ls;
  end

  // Count LS wins over an eligible IF, saturating; any IF win clears the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_grant_if) begin
      r_starve_cnt <= '0;
    end else if (w_grant_ls && i_if_elig && (r_starve_cnt != CNT_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ysyx_22051086_mem_arb.sv
// rtl/ysyx_22051086_mem_arb.sv - single-outstanding IF/LS memory arbiter with fetch flush
module ysyx_22051086_mem_arb
  import ysyx_22051086_mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  ysyx_22051086_mem_arb_if.slave io_bus
);
  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic                  r_owner;
  logic                  r_drop;
  logic                  r_wen;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wmask;

  logic                  w_idle;
  logic                  w_if_elig;
  logic [1:0]            w_grant;
  logic                  w_grant_if;
  logic                  w_grant_ls;
  logic                  w_resp_fire;
  logic                  w_if_kill;
  logic                  w_if_resp;
  logic                  w_ls_resp;

  // Reset gates the IDLE strobe so no ready escapes while reset is held.
  assign w_idle    = (r_state == ST_IDLE) && i_rst_n;
  assign w_if_elig = io_bus.if_req_valid && !io_bus.if_flush;

  ysyx_22051086_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_idle    (w_idle),
    .i_if_elig (w_if_elig),
    .i_ls_elig (io_bus.ls_req_valid),
    .o_grant   (w_grant)
  );

  assign w_grant_if = w_grant[GNT_IF];
  assign w_grant_ls = w_grant[GNT_LS];
  assign w_if_kill  = (r_owner == OWN_IF) && io_bus.if_flush;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; a response only counts while waiting for one.
  always_comb begin
    w_state_nxt = r_state;
    w_resp_fire = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_if || w_grant_ls) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (io_bus.mem_req_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (io_bus.mem_resp_valid) begin
          w_resp_fire = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winning request; a fetch flush while in flight marks its response stale.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner <= OWN_IF;
      r_drop  <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_grant_ls) begin
      r_owner <= OWN_LS;
      r_drop  <= 1'b0;
      r_wen   <= io_bus.ls_req_wen;
      r_addr  <= io_bus.ls_req_addr;
      r_wdata <= io_bus.ls_req_wdata;
      r_wmask <= io_bus.ls_req_wmask;
    end else if (w_grant_if) begin
      r_owner <= OWN_IF;
      r_drop  <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= io_bus.if_req_addr;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if ((r_state != ST_IDLE) && w_if_kill) begin
      r_drop  <= 1'b1;
    end
  end

  assign w_ls_resp = w_resp_fire && (r_owner == OWN_LS);
  assign w_if_resp = w_resp_fire && (r_owner == OWN_IF) && !r_drop && !io_bus.if_flush;

  assign io_bus.if_req_ready  = w_grant_if;
  assign io_bus.ls_req_ready  = w_grant_ls;
  assign io_bus.if_resp_valid = w_if_resp;
  assign io_bus.if_resp_data  = w_if_resp ? io_bus.mem_resp_data : '0;
  assign io_bus.ls_resp_valid = w_ls_resp;
  assign io_bus.ls_resp_data  = w_ls_resp ? io_bus.mem_resp_data : '0;
  assign io_bus.mem_req_valid = (r_state == ST_ISSUE);
  assign io_bus.mem_req_addr  = r_addr;
  assign io_bus.mem_req_wen   = r_wen;
  assign io_bus.mem_req_wdata = r_wdata;
  assign io_bus.mem_req_wmask = r_wmask;
  assign io_bus.busy          = (r_state != ST_IDLE);
endmodule

// File: tb/tb_ysyx_22051086_mem_arb.sv
// tb/tb_ysyx_22051086_mem_arb.sv - self-checking bench for the IF/LS memory arbiter
module tb_ysyx_22051086_mem_arb;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  ysyx_22051086_mem_arb_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  ysyx_22051086_mem_arb #(
    .ADDR_W     (64),
    .DATA_W     (64),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req_valid   = 1'b0;
    bus.if_req_addr    = '0;
    bus.if_flush       = 1'b0;
    bus.ls_req_valid   = 1'b0;
    bus.ls_req_addr    = '0;
    bus.ls_req_wen     = 1'b0;
    bus.ls_req_wdata   = '0;
    bus.ls_req_wmask   = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
  endtask

  // Transaction-level reference: one pending request record plus a starvation tally.
  bit          m_pending, m_sent, m_is_ls, m_stale, m_wen;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wmask;
  int          m_starve;
  bit          e_if_ok, e_ls_win, e_if_win, e_resp;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy",   bus.busy, 0);
      chk("rst_mvalid", bus.mem_req_valid, 0);
      chk("rst_ready",  {bus.if_req_ready, bus.ls_req_ready}, 0);
      chk("rst_resp",   {bus.if_resp_valid, bus.ls_resp_valid}, 0);
      chk("rst_maddr",  bus.mem_req_addr, 0);
      m_pending = 0; m_sent = 0; m_is_ls = 0; m_stale = 0; m_wen = 0;
      m_addr = '0; m_wdata = '0; m_wmask = '0; m_starve = 0;
    end else begin
      e_if_ok  = bus.if_req_valid && !bus.if_flush;
      e_ls_win = !m_pending && bus.ls_req_valid && !(m_starve == STARVE_MAX && e_if_ok);
      e_if_win = !m_pending && e_if_ok && !e_ls_win;
      e_resp   = m_pending && m_sent && bus.mem_resp_valid;
      chk("mon_if_ready", bus.if_req_ready, e_if_win);
      chk("mon_ls_ready", bus.ls_req_ready, e_ls_win);
      chk("mon_busy",     bus.busy, m_pending);
      chk("mon_mvalid",   bus.mem_req_valid, m_pending && !m_sent);
      chk("mon_if_resp",  bus.if_resp_valid, e_resp && !m_is_ls && !m_stale && !bus.if_flush);
      chk("mon_ls_resp",  bus.ls_resp_valid, e_resp && m_is_ls);
      if (e_resp && !m_is_ls && !m_stale && !bus.if_flush)
        chk("mon_if_data", bus.if_resp_data, bus.mem_resp_data);
      if (e_resp && m_is_ls && !m_wen)
        chk("mon_ls_data", bus.ls_resp_data, bus.mem_resp_data);
      if (m_pending && !m_sent) begin
        chk("mon_maddr",  bus.mem_req_addr, m_addr);
        chk("mon_mwen",   bus.mem_req_wen, m_wen);
        chk("mon_mwdata", bus.mem_req_wdata, m_wdata);
        chk("mon_mwmask", bus.mem_req_wmask, m_wmask);
      end
      if (e_ls_win || e_if_win) begin
        m_pending = 1; m_sent = 0; m_stale = 0; m_is_ls = e_ls_win;
        m_addr  = e_ls_win ? bus.ls_req_addr : bus.if_req_addr;
        m_wen   = e_ls_win ? bus.ls_req_wen : 1'b0;
        m_wdata = e_ls_win ? bus.ls_req_wdata : 64'd0;
        m_wmask = e_ls_win ? bus.ls_req_wmask : 8'd0;
        if (e_if_win) m_starve = 0;
        else if (e_if_ok && m_starve < STARVE_MAX) m_starve++;
      end else if (m_pending) begin
        if (!m_is_ls && bus.if_flush) m_stale = 1;
        if (e_resp) m_pending = 0;
        else if (!m_sent && bus.mem_req_ready) m_sent = 1;
      end
    end
  end

  // Both requesters held valid: report which arbitration (1-based) first goes to IF.
  task automatic starve_run(input string tag, input int exp_pos);
    int n_grant = 0;
    int if_pos  = -1;
    int cyc     = 0;
    bus.if_req_valid   = 1'b1;
    bus.if_req_addr    = 64'h8000_2000;
    bus.ls_req_valid   = 1'b1;
    bus.ls_req_addr    = 64'h8000_3000;
    bus.ls_req_wen     = 1'b0;
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h1234;
    while (if_pos < 0 && cyc < 60) begin
      #1;
      if (bus.ls_req_ready) n_grant++;
      if (bus.if_req_ready) begin
        n_grant++;
        if_pos = n_grant;
      end
      tick();
      cyc++;
    end
    chk({tag, "_if_pos"}, if_pos, exp_pos);
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_drain"}, bus.busy, 0);
    clear_inputs();
  endtask

  int pulses;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_busy",   bus.busy, 0);
    chk("reset_mvalid", bus.mem_req_valid, 0);
    chk("reset_maddr",  bus.mem_req_addr, 0);

    // Single fetch against zero-wait memory.
    tick();
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 64'h8000_0000;
    bus.mem_req_ready = 1'b1;
    #1 chk("fetch_ready_T", bus.if_req_ready, 1);
    tick();
    bus.if_req_valid = 1'b0;
    #1 chk("fetch_mvalid_T1", bus.mem_req_valid, 1);
    chk("fetch_maddr_T1", bus.mem_req_addr, 64'h8000_0000);
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h0010_0073;
    #1 chk("fetch_resp_T2", bus.if_resp_valid, 1);
    chk("fetch_data_T2", bus.if_resp_data, 64'h0010_0073);
    tick();
    bus.mem_resp_valid = 1'b0;
    #1 chk("fetch_idle_T3", bus.busy, 0);

    // Store held in ISSUE by three cycles of backpressure.
    tick();
    bus.ls_req_valid  = 1'b1;
    bus.ls_req_addr   = 64'h8000_1000;
    bus.ls_req_wen    = 1'b1;
    bus.ls_req_wdata  = 64'hdead_beef;
    bus.ls_req_wmask  = 8'h0f;
    bus.mem_req_ready = 1'b0;
    #1 chk("store_ready", bus.ls_req_ready, 1);
    tick();
    bus.ls_req_valid = 1'b0;
    bus.ls_req_wdata = 64'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("store_hold_valid", bus.mem_req_valid, 1);
      chk("store_hold_addr",  bus.mem_req_addr, 64'h8000_1000);
      chk("store_hold_wdata", bus.mem_req_wdata, 64'hdead_beef);
      chk("store_hold_wmask", bus.mem_req_wmask, 8'h0f);
      chk("store_hold_wen",   bus.mem_req_wen, 1);
      tick();
    end
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.ls_resp_valid) pulses++;
      tick();
    end
    bus.mem_resp_valid = 1'b0;
    chk("store_resp_pulses", pulses, 1);
    clear_inputs();

    // Simultaneous requests: LS first, IF forced through on the 5th arbitration.
    tick();
    starve_run("starve", STARVE_MAX + 1);

    // Flush during WAIT of a fetch.
    tick();
    bus.if_req_valid  = 1'b1;
    bus.if_req_addr   = 64'h8000_0040;
    bus.mem_req_ready = 1'b1;
    #1 chk("fw_ready", bus.if_req_ready, 1);
    tick();
    bus.if_req_valid = 1'b0;
    tick();
    bus.if_flush = 1'b1;
    tick();
    bus.if_flush       = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h5555;
    #1 chk("fw_no_resp", bus.if_resp_valid, 0);
    tick();
    bus.mem_resp_valid = 1'b0;
    bus.ls_req_valid   = 1'b1;
    bus.ls_req_addr    = 64'h8000_0800;
    bus.ls_req_wen     = 1'b0;
    #1 chk("fw_idle", bus.busy, 0);
    chk("fw_ls_ready", bus.ls_req_ready, 1);
    tick();
    bus.ls_req_valid = 1'b0;
    tick();
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 64'h7777;
    #1 chk("fw_ls_resp", bus.ls_resp_valid, 1);
    chk("fw_ls_data", bus.ls_resp_data, 64'h7777);
    tick();
    clear_inputs();

    // Flush in IDLE blocks the fetch grant.
    tick();
    bus.if_req_valid = 1'b1;
    bus.if_flush     = 1'b1;
    #1 chk("fi_no_ready", bus.if_req_ready, 0);
    tick();
    #1 chk("fi_idle", bus.busy, 0);
    clear_inputs();

    // Asynchronous reset while in ISSUE, with a non-zero starvation count.
    tick();
    bus.if_req_valid = 1'b1;
    bus.ls_req_valid = 1'b1;
    bus.ls_req_addr  = 64'h8000_4000;
    #1 chk("ar_ls_ready", bus.ls_req_ready, 1);
    tick();
    bus.if_req_valid = 1'b0;
    bus.ls_req_valid = 1'b0;
    #1 chk("ar_issue", bus.mem_req_valid, 1);
    #1 rst_n = 1'b0;
    #1 chk("ar_mvalid_drop", bus.mem_req_valid, 0);
    chk("ar_busy_drop", bus.busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.mem_resp_valid = 1'b1;
    #1 chk("ar_late_resp", {bus.if_resp_valid, bus.ls_resp_valid}, 0);
    tick();
    clear_inputs();
    starve_run("post_rst", STARVE_MAX + 1);

    // Randomized traffic checked by the reference monitor.
    for (int i = 0; i < 3000; i++) begin
      tick();
      bus.if_req_valid   = ($urandom_range(0, 9) < 6);
      bus.if_req_addr    = {$urandom, $urandom};
      bus.if_flush       = ($urandom_range(0, 9) == 0);
      bus.ls_req_valid   = ($urandom_range(0, 9) < 5);
      bus.ls_req_addr    = {$urandom, $urandom};
      bus.ls_req_wen     = 1'($urandom_range(0, 1));
      bus.ls_req_wdata   = {$urandom, $urandom};
      bus.ls_req_wmask   = 8'($urandom_range(0, 255));
      bus.mem_req_ready  = ($urandom_range(0, 9) < 6);
      bus.mem_resp_valid = ($urandom_range(0, 9) < 5);
      bus.mem_resp_data  = {$urandom, $urandom};
    end
    tick();
    clear_inputs();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
